// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, header size, default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The CSUM state exists only when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

    // Length header is a 16-bit big-endian word count
    localparam int HDR_LEN       = 2;
    localparam int DEFAULT_DEPTH = 4096;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

    // Big-endian join of the two header bytes
    function automatic logic [15:0] hdr_words(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream in, imem write port and loader status out.
// Latency: n/a (signal bundle only).
// Backpressure: host holds in_valid/in_data until in_ready is seen high at posedge.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error, word_count
    );

    // Host / memory side
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error, word_count
    );
endinterface

// File: rtl/imem_loader_word_pack.sv
// Packs accepted bytes MSB-first into 32-bit words.
// Latency: word_ready pulses one cycle after the 4th byte of a word is accepted.
// Backpressure: none; caller only asserts byte_vld for accepted bytes. Reset drops any partial word.
module word_pack (
    input  logic        clk,
    input  logic        rs,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_ready
);
    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;

    // Shift bytes in and strobe once the fourth byte of a word has landed
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            byte_cnt   <= '0;
            shift_q    <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= byte_vld && (byte_cnt == 2'd3);
            if (byte_vld) begin
                shift_q  <= {shift_q[23:0], byte_dat};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    // Shift register is not touched during the strobe cycle, so the word is stable there
    assign word_dat = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Parses host byte stream (16-bit BE word count, then words) into imem writes; optional checksum via IMEM_LOADER_CSUM_EN.
// Latency: mem_we one cycle after a word's 4th byte; done one cycle after the final write (or final header/checksum byte).
// Backpressure: in_ready low outside the parsing states and during the final write cycle; arbitrary in_valid gaps tolerated.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BASE  = 0
) (
    input logic          clk,
    input logic          rs,
    imem_loader_if.slave bus
);
    state_t      state, state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len_n;
    logic [15:0] words_left;
    logic [15:0] word_count;
    logic        in_ready;
    logic        accept;
    logic        pack_vld;
    logic        word_ready;
    logic        last_word;
    logic        len_too_big;
    logic [31:0] word_dat;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    assign len_n       = hdr_words(len_hi, bus.in_data);
    assign len_too_big = {16'd0, len_n} > 32'(DEPTH);
    // Final word is being written: stop taking bytes until the FSM moves on
    assign last_word   = word_ready && (words_left == 16'd1);
    assign accept      = bus.in_valid && in_ready;
    assign pack_vld    = accept && (state == DATA);

    assign in_ready = !rs && ((state == LEN_HI) || (state == LEN_LO) ||
                              ((state == DATA) && !last_word)
`ifdef IMEM_LOADER_CSUM_EN
                              || (state == CSUM)
`endif
                             );

    word_pack u_word_pack (
        .clk        (clk),
        .rs         (rs),
        .byte_vld   (pack_vld),
        .byte_dat   (bus.in_data),
        .word_dat   (word_dat),
        .word_ready (word_ready)
    );

    // State register
    always_ff @(posedge clk or posedge rs) begin
        if (rs) state <= LEN_HI;
        else    state <= state_nxt;
    end

    // Next-state decode; DONE and ERROR are sticky until reset
    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI: if (accept) state_nxt = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_too_big)        state_nxt = ERROR;
                    else if (len_n == 16'd0)
`ifdef IMEM_LOADER_CSUM_EN
                                            state_nxt = CSUM;
`else
                                            state_nxt = DONE;
`endif
                    else                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (last_word)
`ifdef IMEM_LOADER_CSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
`endif
            default: state_nxt = state;
        endcase
    end

    // Header capture, remaining-word tracking, write counter and running checksum
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            len_hi     <= '0;
            words_left <= '0;
            word_count <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            if (accept && (state == LEN_HI)) len_hi <= bus.in_data;
            if (accept && (state == LEN_LO)) words_left <= len_n;
            else if (word_ready)             words_left <= words_left - 16'd1;
            if (word_ready) word_count <= word_count + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
            if (accept && (state == LEN_LO)) csum <= '0;
            else if (pack_vld)               csum <= csum ^ bus.in_data;
`endif
        end
    end

    // word_count still holds this word's index during the write cycle
    assign bus.mem_addr   = word_ready ? (32'(BASE) + {16'd0, word_count}) : 32'd0;
    assign bus.mem_we     = word_ready;
    assign bus.mem_wdata  = word_dat;
    assign bus.in_ready   = in_ready;
    assign bus.word_count = word_count;
    assign bus.core_hold  = (state != DONE);
    assign bus.done       = (state == DONE);
    assign bus.error      = (state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, hand corner sequences, randomized streams vs reference model.
// Latency: checks write timing and done latency relative to observed accept/write cycles.
// Backpressure: drives in_valid with configurable or random idle gaps; honours in_ready.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int BASE  = 0;

    logic clk = 1'b0;
    logic rs;
    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] s;
        int           nb;
        int           gap;
        int           nw;
        logic [63:0]  w0;
        logic [63:0]  w1;
        logic         e_done;
        logic         e_err;
        int           e_wc;
        logic         ign;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  stim_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] wr_q[$];
    vec_t        vecs[$];

    int   cyc           = 0;
    int   last_acc_cyc  = -1;
    int   last_we_cyc   = -1;
    int   done_rise_cyc = -1;
    logic prev_done     = 1'b0;

    // Cycle counter and byte-acceptance timestamp
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) last_acc_cyc <= cyc;
    end

    // Write log and done-rise timestamp
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_q.push_back({bus.mem_addr, bus.mem_wdata});
            last_we_cyc = cyc;
        end
        if (bus.done && !prev_done) done_rise_cyc = cyc;
        prev_done = bus.done;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [127:0] raw, input int nb, input int gap, input int nw,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic e_done, input logic e_err, input int wc, input logic ign);
        vec_t v;
        v.s      = raw << (128 - 8 * nb);
        v.nb     = nb;
        v.gap    = gap;
        v.nw     = nw;
        v.w0     = {32'd0, d0};
        v.w1     = {32'd1, d1};
        v.e_done = e_done;
        v.e_err  = e_err;
        v.e_wc   = wc;
        v.ign    = ign;
        return v;
    endfunction

    task automatic do_reset(input logic hold_valid);
        @(negedge clk);
        rs           = 1'b1;
        bus.in_valid = hold_valid;
        bus.in_data  = 8'hA5;
        @(negedge clk);
        chk("reset_state",
            128'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.word_count,
                  bus.done, bus.error, bus.core_hold}),
            128'({1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rs           = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // gap < 0 selects a random idle gap per byte
    task automatic send(input int gap);
        logic ok, acc, rdy;
        int   g;
        ok = 1'b1;
        for (int i = 0; i < stim_q.size() && ok; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = stim_q[i];
                rdy          = bus.in_ready;
                @(posedge clk);
                acc = rdy;
            end
            if (!acc) begin
                chk("byte_accepted", 128'(acc), 128'd1);
                ok = 1'b0;
            end
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_check(input string nm, input int gap, input logic e_done, input logic e_err, input int e_wc);
        int start, ref_cyc;
        start = wr_q.size();
        send(gap);
        repeat (6) @(negedge clk);
        chk({nm, "_nwr"}, 128'(wr_q.size() - start), 128'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size(); i++)
            if (start + i < wr_q.size())
                chk($sformatf("%s_wr%0d", nm, i), 128'(wr_q[start + i]), 128'(exp_wr_q[i]));
        chk({nm, "_done"},  128'(bus.done),       128'(e_done));
        chk({nm, "_error"}, 128'(bus.error),      128'(e_err));
        chk({nm, "_wc"},    128'(bus.word_count), 128'(e_wc));
        chk({nm, "_hold"},  128'(bus.core_hold),  128'(!e_done));
        chk({nm, "_rdy"},   128'(bus.in_ready),   128'd0);
        if (e_done) begin
`ifdef IMEM_LOADER_CSUM_EN
            ref_cyc = last_acc_cyc;
`else
            ref_cyc = (exp_wr_q.size() > 0) ? last_we_cyc : last_acc_cyc;
`endif
            chk({nm, "_done_lat"}, 128'(done_rise_cyc), 128'(ref_cyc + 1));
        end
    endtask

    task automatic offer_ignored(input string nm, input logic e_done, input logic e_err);
        int   start;
        logic any;
        start = wr_q.size();
        any   = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h3C;
            any          = any | bus.in_ready;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_rdy"},    128'(any),                  128'd0);
        chk({nm, "_nwr"},    128'(wr_q.size() - start),  128'd0);
        chk({nm, "_status"}, 128'({bus.done, bus.error}), 128'({e_done, e_err}));
    endtask

    // Reference model: word count header, then words split MSB-first, checksum is XOR of data bytes
    task automatic build_random(output logic e_done, output logic e_err, output int e_wc);
        int          n, r;
        logic [31:0] w;
        logic [7:0]  b, x;
`ifdef IMEM_LOADER_CSUM_EN
        logic        bad;
`endif
        stim_q.delete();
        exp_wr_q.delete();
        r = int'($urandom_range(0, 9));
        if (r == 0)      n = 0;
        else if (r == 1) n = int'($urandom_range(DEPTH + 1, 65535));
        else             n = int'($urandom_range(1, 6));
        stim_q.push_back(8'(n >> 8));
        stim_q.push_back(8'(n));
        if (n > DEPTH) begin
            e_done = 1'b0;
            e_err  = 1'b1;
            e_wc   = 0;
            return;
        end
        x = 8'h00;
        for (int wi = 0; wi < n; wi++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                b = w[31 - 8 * k -: 8];
                stim_q.push_back(b);
                x = x ^ b;
            end
            exp_wr_q.push_back({32'(BASE + wi), w});
        end
        e_wc   = n;
        e_done = 1'b1;
        e_err  = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        bad = ($urandom_range(0, 3) == 0);
        if (bad) begin
            stim_q.push_back(x ^ 8'($urandom_range(1, 255)));
            e_done = 1'b0;
            e_err  = 1'b1;
        end else begin
            stim_q.push_back(x);
        end
`endif
    endtask

    initial begin
        vec_t v;
        int   start;
        logic e_done, e_err;
        int   e_wc;

        rs           = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

`ifdef IMEM_LOADER_CSUM_EN
        vecs.push_back(mk(128'h00028C090004AC0A00082F, 11, 0, 2, 32'h8C090004, 32'hAC0A0008, 1'b1, 1'b0, 2, 1'b1));
        vecs.push_back(mk(128'h00028C090004AC0A00082F, 11, 2, 2, 32'h8C090004, 32'hAC0A0008, 1'b1, 1'b0, 2, 1'b0));
        vecs.push_back(mk(128'h1001, 2, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(128'h000000, 3, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk(128'h00010102030404, 7, 0, 1, 32'h01020304, 32'h0, 1'b1, 1'b0, 1, 1'b0));
        vecs.push_back(mk(128'h00010102030405, 7, 0, 1, 32'h01020304, 32'h0, 1'b0, 1'b1, 1, 1'b1));
`else
        vecs.push_back(mk(128'h00028C090004AC0A0008, 10, 0, 2, 32'h8C090004, 32'hAC0A0008, 1'b1, 1'b0, 2, 1'b1));
        vecs.push_back(mk(128'h00028C090004AC0A0008, 10, 2, 2, 32'h8C090004, 32'hAC0A0008, 1'b1, 1'b0, 2, 1'b0));
        vecs.push_back(mk(128'h1001, 2, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(128'h0000, 2, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk(128'h000101020304, 6, 0, 1, 32'h01020304, 32'h0, 1'b1, 1'b0, 1, 1'b0));
`endif

        // Directed vector table
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            do_reset(1'b0);
            stim_q.delete();
            for (int i = 0; i < v.nb; i++) stim_q.push_back(v.s[127 - 8 * i -: 8]);
            exp_wr_q.delete();
            if (v.nw > 0) exp_wr_q.push_back(v.w0);
            if (v.nw > 1) exp_wr_q.push_back(v.w1);
            run_check($sformatf("vec%0d", k), v.gap, v.e_done, v.e_err, v.e_wc);
            if (v.ign) offer_ignored($sformatf("vec%0d_ign", k), v.e_done, v.e_err);
        end

        // N equal to DEPTH is legal: loader waits for data
        do_reset(1'b0);
        stim_q = '{8'h10, 8'h00};
        send(0);
        @(negedge clk);
        chk("n_eq_depth_err",  128'(bus.error),     128'd0);
        chk("n_eq_depth_rdy",  128'(bus.in_ready),  128'd1);
        chk("n_eq_depth_hold", 128'(bus.core_hold), 128'd1);

        // Reset in the middle of the second word, then a fresh stream
        do_reset(1'b0);
        stim_q = '{8'h00, 8'h02, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        start  = wr_q.size();
        send(0);
        repeat (3) @(negedge clk);
        chk("midload_nwr", 128'(wr_q.size() - start), 128'd1);
        if (start < wr_q.size()) chk("midload_wr0", 128'(wr_q[start]), 128'({32'd0, 32'h11121314}));
        chk("midload_wc", 128'(bus.word_count), 128'd1);
        do_reset(1'b1);
`ifdef IMEM_LOADER_CSUM_EN
        stim_q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
`else
        stim_q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
        exp_wr_q = '{{32'd0, 32'h01020304}};
        run_check("rst_fresh", 0, 1'b1, 1'b0, 1);

        // Randomized streams against the reference model
        for (int it = 0; it < 30; it++) begin
            do_reset(1'b0);
            build_random(e_done, e_err, e_wc);
            run_check($sformatf("rnd%0d", it), -1, e_done, e_err, e_wc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, instruction-memory capacity in words.
REQ-002 SHALL have parameter BASE, default 0, first word index written.
REQ-003 SHALL have ports clk  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rs  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid  in  1 and in_data  in  8, the byte stream from the host.
REQ-006 SHALL have port in_ready  out  1  byte accepted when in_valid & in_ready at posedge.
REQ-007 SHALL have ports mem_we  out  1, mem_addr  out  32 (word index), mem_wdata  out  32, the imem write port.
REQ-008 SHALL have ports core_hold  out  1, done  out  1, error  out  1, word_count  out  16.

Function
REQ-009 SHALL use states LEN_HI, LEN_LO, DATA, CSUM (macro only), DONE, ERROR.
REQ-010 SHALL accept the stream as a 16-bit big-endian word count N, then N*4 data bytes.
REQ-011 SHALL assert in_ready only in LEN_HI, LEN_LO, DATA, CSUM.
REQ-012 SHALL pack each 4 data bytes MSB-first: first byte -> mem_wdata[31:24].
REQ-013 SHALL pulse mem_we for exactly one cycle, in the cycle after the 4th byte of a word is accepted; mem_addr = BASE + word index, mem_wdata held stable in that cycle.
REQ-014 SHALL increment word_count on each mem_we pulse, counting from 0.
REQ-015 SHALL go to ERROR on LEN_LO acceptance when N > DEPTH; no writes occur.
REQ-016 SHALL treat N = 0 as complete: DONE (or CSUM with macro) immediately after LEN_LO.
REQ-017 SHALL assert done and drop core_hold one cycle after the final mem_we pulse (N=0: one cycle after LEN_LO / checksum acceptance).
REQ-018 SHALL hold core_hold = 1 in every state except DONE.
REQ-019 SHALL remain in DONE or ERROR until rs; bytes offered there are ignored (in_ready = 0).
REQ-020 SHALL tolerate in_valid gaps of any length between bytes, with no change in output.

Reset
REQ-021 SHALL, while rs = 1, force state LEN_HI, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, done 0, error 0, core_hold 1.
REQ-022 SHALL, on rs asserted mid-load, discard any partial word; words already written stay in memory; the next byte is parsed as LEN_HI.

Configuration
REQ-023 SHALL, with IMEM_LOADER_CSUM_EN defined, expect one trailing byte equal to the XOR of all N*4 data bytes; match -> DONE, mismatch -> ERROR (core_hold stays 1).
REQ-024 SHALL, without IMEM_LOADER_CSUM_EN, omit the CSUM state and checksum logic and enter DONE after the last data byte.

Structure
REQ-025 SHALL place state encoding, the header length (2 bytes) and the default DEPTH in shared package imem_loader_pkg.
REQ-026 SHALL implement byte assembly in sub-module word_pack (2-bit byte counter, 32-bit shift register, word_ready strobe).

Verification
REQ-027 SHALL check: bytes 00 02 8C 09 00 04 AC 0A 00 08 -> mem_we at addr 0 data 32'h8C090004, then addr 1 data 32'hAC0A0008; done 1 one cycle later; word_count 2.
REQ-028 SHALL check: header 10 01 (N=4097) with DEPTH 4096 -> error 1, no mem_we, in_ready 0, core_hold 1.
REQ-029 SHALL check: the first case with in_valid toggled 1-0-0-1 per byte -> identical writes and data.
REQ-030 SHALL check: rs pulsed after 6 data bytes, then a fresh stream 00 01 01 02 03 04 -> single write at addr 0 data 32'h01020304.
REQ-031 SHALL check with IMEM_LOADER_CSUM_EN: 00 01 01 02 03 04 04 -> done 1; the same stream with trailing 05 -> error 1.
REQ-032 SHALL check: header 00 00 -> done 1 with no mem_we and word_count 0.
